// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive framer.
// PS2_RX_PARITY_CHECK_EN selects whether the parity bit is enforced.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE    = 2'b00;
    localparam err_code_t ERR_PARITY  = 2'b01;
    localparam err_code_t ERR_FRAME   = 2'b10;
    localparam err_code_t ERR_TIMEOUT = 2'b11;

    localparam int FRAME_LEN = 11;
    // start, parity and stop surround the payload
    localparam int DATA_BITS = FRAME_LEN - 3;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer followed by an agreement filter for one PS/2 pin.
// Build option PS2_RX_PARITY_CHECK_EN does not affect this block.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    localparam int CW = 4;

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // the line flips only once FILTER_LEN samples in a row disagree with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            filt <= 1'b1;
            cnt  <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 != filt) begin
                if (cnt == CW'(FILTER_LEN - 1)) begin
                    filt <= s2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_framer.sv
// PS/2 device-to-host receive framer: pin filtering, 11-bit deframing, error strobes.
// Define PS2_RX_PARITY_CHECK_EN to enforce odd parity (error code 01).
module ps2_rx_framer
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       sys_clk_i,
    input  logic       sys_reset_i,
    input  logic       ps2_c_i,
    input  logic       ps2_d_i,
    input  logic       rx_inhibit_i,
    output logic [7:0] rx_dat_o,
    output logic       rx_stb_o,
    output logic       rx_err_o,
    output logic [1:0] rx_err_code_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          c_filt;
    logic          d_filt;
    logic          c_prev;
    logic          fall;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [TW-1:0] tcnt;
`ifdef PS2_RX_PARITY_CHECK_EN
    logic          par_acc;
    logic          par_ok;
`endif

    ps2_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filt (
        .clk (sys_clk_i),
        .rst (sys_reset_i),
        .raw (ps2_c_i),
        .filt(c_filt)
    );

    ps2_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_dat_filt (
        .clk (sys_clk_i),
        .rst (sys_reset_i),
        .raw (ps2_d_i),
        .filt(d_filt)
    );

    assign fall = c_prev & ~c_filt;

    always_ff @(posedge sys_clk_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            c_prev        <= 1'b1;
            state         <= IDLE;
            bit_cnt       <= '0;
            shreg         <= '0;
            tcnt          <= '0;
            rx_dat_o      <= '0;
            rx_stb_o      <= 1'b0;
            rx_err_o      <= 1'b0;
            rx_err_code_o <= ERR_NONE;
`ifdef PS2_RX_PARITY_CHECK_EN
            par_acc       <= 1'b0;
            par_ok        <= 1'b0;
`endif
        end else begin
            c_prev        <= c_filt;
            rx_stb_o      <= 1'b0;
            rx_err_o      <= 1'b0;
            rx_err_code_o <= ERR_NONE;

            // host owns the bus: drop everything, including a completing frame
            if (rx_inhibit_i) begin
                state   <= IDLE;
                bit_cnt <= '0;
                tcnt    <= '0;
            end else if (state == IDLE) begin
                tcnt <= '0;
                if (fall && !d_filt) begin
                    bit_cnt <= '0;
                    state   <= DATA;
`ifdef PS2_RX_PARITY_CHECK_EN
                    par_acc <= 1'b0;
`endif
                end
            end else if (fall) begin
                tcnt <= '0;
                case (state)
                    DATA: begin
                        shreg   <= {d_filt, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
`ifdef PS2_RX_PARITY_CHECK_EN
                        par_acc <= par_acc ^ d_filt;
`endif
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
                        par_ok <= par_acc ^ d_filt;
`endif
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!d_filt) begin
                            rx_err_o      <= 1'b1;
                            rx_err_code_o <= ERR_FRAME;
`ifdef PS2_RX_PARITY_CHECK_EN
                        end else if (!par_ok) begin
                            rx_err_o      <= 1'b1;
                            rx_err_code_o <= ERR_PARITY;
`endif
                        end else begin
                            rx_dat_o <= shreg;
                            rx_stb_o <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (tcnt == TW'(TIMEOUT_CYCLES)) begin
                state         <= IDLE;
                tcnt          <= '0;
                rx_err_o      <= 1'b1;
                rx_err_code_o <= ERR_TIMEOUT;
            end else begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_framer.sv
// Directed bench for ps2_rx_framer with immediate-assertion checks.
// Expectations follow PS2_RX_PARITY_CHECK_EN when it is defined.
module tb_ps2_rx_framer;

    localparam int FL = 4;
    localparam int TO = 100;
    localparam int HP = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       c;
    logic       d;
    logic       inh;
    logic [7:0] dat;
    logic       stb;
    logic       err;
    logic [1:0] code;

    int total = 0;
    int bad = 0;
    int stb_n = 0;
    int err_n = 0;
    int both_n = 0;
    int snap_s;
    int snap_e;
    bit found;

    ps2_rx_framer #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk_i    (clk),
        .sys_reset_i  (rst),
        .ps2_c_i      (c),
        .ps2_d_i      (d),
        .rx_inhibit_i (inh),
        .rx_dat_o     (dat),
        .rx_stb_o     (stb),
        .rx_err_o     (err),
        .rx_err_code_o(code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stb) stb_n++;
        if (err) err_n++;
        if (stb && err) both_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input logic p,
                                       input logic s);
        return {s, p, b, 1'b0};
    endfunction

    // drives n bits; the clock is left low after the last falling edge
    task automatic send(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            d = f[i];
            repeat (HP) @(negedge clk);
            c = 1'b0;
            if (i < n - 1) begin
                repeat (HP) @(negedge clk);
                c = 1'b1;
            end
        end
    endtask

    task automatic rise();
        repeat (HP) @(negedge clk);
        c = 1'b1;
        d = 1'b1;
    endtask

    // pulse must appear exactly 7 negedges after the raw stop fall
    task automatic expect_pulse(input string tag, input logic s, input logic e,
                                input logic [1:0] ec, input logic [7:0] ed);
        repeat (6) @(negedge clk);
        chk({tag, "_pre"}, {stb, err}, 2'b00);
        @(negedge clk);
        chk({tag, "_stb"}, stb, s);
        chk({tag, "_err"}, err, e);
        chk({tag, "_code"}, code, ec);
        chk({tag, "_dat"}, dat, ed);
        @(negedge clk);
        chk({tag, "_post"}, {stb, err}, 2'b00);
        rise();
    endtask

    initial begin
        rst = 1'b1;
        c = 1'b1;
        d = 1'b1;
        inh = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dat", dat, 8'h00);
        chk("rst_pulses", {stb, err, code}, 4'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        send(mk(8'h63, 1'b1, 1'b1), 11);
        expect_pulse("good63", 1'b1, 1'b0, 2'b00, 8'h63);

        send(mk(8'h63, 1'b0, 1'b1), 11);
`ifdef PS2_RX_PARITY_CHECK_EN
        expect_pulse("badpar", 1'b0, 1'b1, 2'b01, 8'h63);
`else
        expect_pulse("badpar", 1'b1, 1'b0, 2'b00, 8'h63);
`endif

        send(mk(8'h3c, 1'b1, 1'b0), 11);
        expect_pulse("frame", 1'b0, 1'b1, 2'b10, 8'h63);

        send(mk(8'h63, 1'b1, 1'b1), 5);
        rise();
        found = 1'b0;
        for (int i = 0; i < TO + 60 && !found; i++) begin
            @(negedge clk);
            if (err) begin
                found = 1'b1;
                chk("tmo_code", code, 2'b11);
                chk("tmo_stb", stb, 1'b0);
            end
        end
        chk("tmo_seen", found, 1'b1);
        repeat (10) @(negedge clk);
        send(mk(8'haa, 1'b1, 1'b1), 11);
        expect_pulse("goodaa", 1'b1, 1'b0, 2'b00, 8'haa);

        // 3-cycle glitch with data low would look like a start bit
        d = 1'b0;
        c = 1'b0;
        repeat (3) @(negedge clk);
        c = 1'b1;
        repeat (20) @(negedge clk);
        send(mk(8'h0f, 1'b1, 1'b1), 11);
        expect_pulse("glitch", 1'b1, 1'b0, 2'b00, 8'h0f);

        repeat (5) @(negedge clk);
        snap_s = stb_n;
        snap_e = err_n;
        send(mk(8'h63, 1'b1, 1'b1), 7);
        rise();
        inh = 1'b1;
        repeat (5) @(negedge clk);
        c = 1'b0;
        repeat (HP) @(negedge clk);
        c = 1'b1;
        repeat (HP) @(negedge clk);
        inh = 1'b0;
        repeat (TO + 20) @(negedge clk);
        chk("inh_stb_n", stb_n, snap_s);
        chk("inh_err_n", err_n, snap_e);
        send(mk(8'h63, 1'b1, 1'b1), 11);
        expect_pulse("after_inh", 1'b1, 1'b0, 2'b00, 8'h63);

        repeat (5) @(negedge clk);
        snap_s = stb_n;
        snap_e = err_n;
        send(mk(8'h55, 1'b1, 1'b1), 4);
        rise();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_dat", dat, 8'h00);
        chk("mrst_pulses", {stb, err, code}, 4'h0);
        rst = 1'b0;
        repeat (TO + 20) @(negedge clk);
        chk("mrst_stb_n", stb_n, snap_s);
        chk("mrst_err_n", err_n, snap_e);
        send(mk(8'haa, 1'b1, 1'b1), 11);
        expect_pulse("after_rst", 1'b1, 1'b0, 2'b00, 8'haa);

        repeat (5) @(negedge clk);
`ifdef PS2_RX_PARITY_CHECK_EN
        chk("stb_total", stb_n, 5);
        chk("err_total", err_n, 3);
`else
        chk("stb_total", stb_n, 6);
        chk("err_total", err_n, 2);
`endif
        chk("never_both", both_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
